// File: rtl/mbist_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mbist_pkg: FSM states, March element ids and C- descriptor table  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  typedef struct packed {
    logic dir_down;
    logic rd_en;
    logic rd_val;
    logic wr_en;
    logic wr_val;
  } elem_desc_t;

  // Elements with both ops always read first, then write, at each address.
  function automatic elem_desc_t elem_desc(input logic [2:0] elem);
    elem_desc_t d;
    case (elem)
      M0:      d = '{dir_down: 1'b0, rd_en: 1'b0, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b0};
      M1:      d = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
      M2:      d = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
      M3:      d = '{dir_down: 1'b1, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
      M4:      d = '{dir_down: 1'b1, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
      M5:      d = '{dir_down: 1'b0, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b0, wr_val: 1'b0};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_cmp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mbist_cmp: 2-stage read compare pipeline and first-fail log       |
// | Log registers exist only when MBIST_FAIL_LOG_EN is defined.       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mbist_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  issue_vld,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [2:0]            issue_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn
);

  logic                  vld1_q, vld2_q, fail_q, fail_d;
  logic [DATA_WIDTH-1:0] exp1_q, exp2_q, syn;
  logic                  mis;

  always_comb begin
    syn    = rdata ^ exp2_q;
    mis    = vld2_q && (syn != '0);
    fail_d = clr ? 1'b0 : (fail_q | mis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      exp1_q <= '0;
      exp2_q <= '0;
      fail_q <= 1'b0;
    end else begin
      vld1_q <= issue_vld;
      vld2_q <= vld1_q;
      exp1_q <= issue_exp;
      exp2_q <= exp1_q;
      fail_q <= fail_d;
    end
  end

  assign fail = fail_q;

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] addr1_q, addr2_q, log_addr_q, log_addr_d;
  logic [2:0]            elem1_q, elem2_q, log_elem_q, log_elem_d;
  logic [DATA_WIDTH-1:0] log_syn_q, log_syn_d;

  // Only the first miscompare since the last start is recorded.
  always_comb begin
    log_addr_d = log_addr_q;
    log_elem_d = log_elem_q;
    log_syn_d  = log_syn_q;
    if (clr) begin
      log_addr_d = '0;
      log_elem_d = '0;
      log_syn_d  = '0;
    end else if (mis && !fail_q) begin
      log_addr_d = addr2_q;
      log_elem_d = elem2_q;
      log_syn_d  = syn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr1_q    <= '0;
      addr2_q    <= '0;
      elem1_q    <= '0;
      elem2_q    <= '0;
      log_addr_q <= '0;
      log_elem_q <= '0;
      log_syn_q  <= '0;
    end else begin
      addr1_q    <= issue_addr;
      addr2_q    <= addr1_q;
      elem1_q    <= issue_elem;
      elem2_q    <= elem1_q;
      log_addr_q <= log_addr_d;
      log_elem_q <= log_elem_d;
      log_syn_q  <= log_syn_d;
    end
  end

  assign fail_addr = log_addr_q;
  assign fail_elem = log_elem_q;
  assign fail_syn  = log_syn_q;
`else
  logic w_unused_log;
  assign w_unused_log = ^{issue_addr, issue_elem};
  assign fail_addr    = '0;
  assign fail_elem    = '0;
  assign fail_syn     = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mbist_march_ctrl: March C- MBIST sequencer, one op per cycle      |
// | Optional first-fail log: define MBIST_FAIL_LOG_EN.                |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn
);

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  drain_cnt_q, drain_cnt_d;
  logic                  done_q, done_d;
  logic                  write_read_q, write_read_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  elem_desc_t            cur_desc, succ_desc, nxt_desc;
  logic                  addr_last, start_accept, rd_issue;

  always_comb begin
    cur_desc     = elem_desc(elem_q);
    succ_desc    = elem_desc(elem_q + 3'd1);
    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = done_q;
    start_accept = 1'b0;
    addr_last    = cur_desc.dir_down ? (addr_q == '0) : (addr_q == C_ADDR_LAST);
    rd_issue     = (state_q == RUN) && cur_desc.rd_en && !phase_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          elem_d       = M0;
          addr_d       = '0;
          phase_d      = 1'b0;
          done_d       = 1'b0;
          start_accept = 1'b1;
        end
      end
      RUN: begin
        if (cur_desc.rd_en && cur_desc.wr_en && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!addr_last) begin
            addr_d = cur_desc.dir_down ? (addr_q - C_ADDR_ONE) : (addr_q + C_ADDR_ONE);
          end else if (elem_q == M5) begin
            state_d     = DRAIN;
            drain_cnt_d = 1'b0;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = succ_desc.dir_down ? C_ADDR_LAST : '0;
          end
        end
      end
      DRAIN: begin
        // Two cycles lets the final M5 read reach the compare stage.
        drain_cnt_d = ~drain_cnt_q;
        if (drain_cnt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every cycle of an element carries that element's write value, which
    // gives the memory its write data one cycle ahead of each write.
    nxt_desc     = elem_desc(elem_d);
    write_read_d = (state_d == RUN) && nxt_desc.wr_en && (!nxt_desc.rd_en || phase_d);
    wdata_d      = ((state_d == RUN) && nxt_desc.wr_en) ? {DATA_WIDTH{nxt_desc.wr_val}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elem_q       <= '0;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      drain_cnt_q  <= 1'b0;
      done_q       <= 1'b0;
      write_read_q <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      drain_cnt_q  <= drain_cnt_d;
      done_q       <= done_d;
      write_read_q <= write_read_d;
      wdata_q      <= wdata_d;
    end
  end

  assign write_read = write_read_q;
  assign address    = addr_q;
  assign wdata      = wdata_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  mbist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_accept),
    .issue_vld  (rd_issue),
    .issue_exp  ({DATA_WIDTH{cur_desc.rd_val}}),
    .issue_addr (addr_q),
    .issue_elem (elem_q),
    .rdata      (rdata),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_syn   (fail_syn)
  );

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mbist_march_ctrl: March C- runs on a 2-cycle-latency memory    |
// | model with injectable stuck-at faults. Revision 1.0               |
// +------------------------------------------------------------------+
module tb_mbist_march_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int N   = 16;
  localparam int OPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          write_read, busy, done, fail;
  logic [AW-1:0] address, fail_addr;
  logic [DW-1:0] wdata, rdata, fail_syn;
  logic [2:0]    fail_elem;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_syn(fail_syn)
  );

  // Memory model: write registered at the edge, read data 2 cycles later.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_p1, rd_p2, fault_mask;
  logic [AW-1:0] fault_a;
  logic          fault_en, fault_sa1, garble;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (fault_en && a == fault_a) return fault_sa1 ? (d | fault_mask) : (d & ~fault_mask);
    return d;
  endfunction

  always @(posedge clk) begin
    if (write_read) mem[address] <= wdata;
    rd_p1 <= faulty(address, mem[address]);
    rd_p2 <= rd_p1;
  end
  assign rdata = rd_p2 ^ {DW{garble}};

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;
  op_t exp_q[$];

  typedef struct {
    bit fault_en;
    bit sa1;
    int faddr;
    int fbit;
    bit extra_starts;
    bit exp_fail;
    int exp_addr;
    int exp_elem;
    int exp_syn;
  } vec_t;
  vec_t vecs[6];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_op(input bit wr, input int a, input logic [DW-1:0] d);
    op_t o;
    o.wr   = wr;
    o.addr = AW'(a);
    o.data = d;
    exp_q.push_back(o);
  endtask

  task automatic push_march();
    exp_q.delete();
    for (int a = 0; a < N; a++) push_op(1'b1, a, 8'h00);
    for (int a = 0; a < N; a++) begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'hFF); end
    for (int a = 0; a < N; a++) begin push_op(1'b0, a, 8'hFF); push_op(1'b1, a, 8'h00); end
    for (int a = N - 1; a >= 0; a--) begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'hFF); end
    for (int a = N - 1; a >= 0; a--) begin push_op(1'b0, a, 8'hFF); push_op(1'b1, a, 8'h00); end
    for (int a = 0; a < N; a++) push_op(1'b0, a, 8'h00);
  endtask

  // Pops one expected op and compares it with what the DUT drives this cycle.
  task automatic check_op(input int cyc, input logic [DW-1:0] prev_wd);
    op_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("sb_empty@%0d", cyc), 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("op@%0d", cyc), {write_read, address}, {e.wr, e.addr});
    if (e.wr) check($sformatf("wdata@%0d", cyc), {prev_wd, wdata}, {e.data, e.data});
  endtask

  task automatic run_march(input vec_t v);
    int            done_cyc;
    logic [DW-1:0] prev_wd;
    fault_en   = v.fault_en;
    fault_sa1  = v.sa1;
    fault_a    = AW'(v.faddr);
    fault_mask = '0;
    fault_mask[v.fbit] = 1'b1;
    push_march();
    @(posedge clk); #1;
    start    = 1'b1;
    prev_wd  = wdata;
    done_cyc = -1;
    for (int cyc = 1; cyc <= OPS + 10 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = v.extra_starts && (cyc == 10 || cyc == 50);
      if (cyc == 1) check("start_clears", {busy, done, fail}, 3'b100);
      if (cyc <= OPS) check_op(cyc, prev_wd);
      else if (cyc <= OPS + 2) check($sformatf("drain@%0d", cyc), {busy, write_read, done}, 3'b100);
      if (done) done_cyc = cyc;
      prev_wd = wdata;
    end
    start = 1'b0;
    check("done_cycle", 64'(done_cyc), 64'd163);
    check("fail", {63'd0, fail}, {63'd0, v.exp_fail});
`ifdef MBIST_FAIL_LOG_EN
    check("fail_log", {fail_addr, fail_elem, fail_syn},
          {AW'(v.exp_addr), 3'(v.exp_elem), DW'(v.exp_syn)});
`else
    check("fail_log_tied", {fail_addr, fail_elem, fail_syn}, '0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", {done, busy, write_read, address}, {3'b100, AW'(N - 1)});
  endtask

  initial begin
    // fault_en sa1 addr bit extra  exp_fail addr elem syn
    vecs[0] = '{0, 0,  0, 0, 0, 0,  0, 0, 8'h00};
    vecs[1] = '{1, 1,  5, 2, 0, 1,  5, 1, 8'h04};
    vecs[2] = '{1, 0,  9, 0, 0, 1,  9, 2, 8'h01};
    vecs[3] = '{0, 0,  0, 0, 1, 0,  0, 0, 8'h00};
    vecs[4] = '{1, 1, 15, 3, 0, 1, 15, 1, 8'h08};
    vecs[5] = '{1, 0,  0, 7, 0, 1,  0, 2, 8'h80};

    rst = 1'b1; start = 1'b0; garble = 1'b0;
    fault_en = 1'b0; fault_sa1 = 1'b0; fault_a = '0; fault_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, fail, write_read, address, wdata, fail_addr, fail_elem, fail_syn}, '0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_march(vecs[i]);

    // Reset at operation 70 with corrupted read data while the pipeline drains.
    fault_en = 1'b0;
    push_march();
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_op(cyc, wdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    garble = 1'b1;
    check("mid_reset", {busy, done, fail, write_read, address, wdata, fail_addr, fail_elem, fail_syn}, '0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      garble = 1'b0;
      check($sformatf("post_reset_quiet%0d", k), {busy, fail, write_read}, 3'b000);
    end
    run_march(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; the test covers all 2**ADDR_WIDTH words (N).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a test.
REQ-006 SHALL have port write_read, output, 1 bit: memory operation, 1 = write and 0 = read.
REQ-007 SHALL have port address, output, ADDR_WIDTH bits: memory address.
REQ-008 SHALL have port wdata, output, DATA_WIDTH bits: memory write data.
REQ-009 SHALL have port rdata, input, DATA_WIDTH bits: memory read data.
REQ-010 SHALL have port busy, output, 1 bit: a test is in progress.
REQ-011 SHALL have port done, output, 1 bit: the test is complete; it stays high until the next start or reset.
REQ-012 SHALL have port fail, output, 1 bit: a sticky flag set on any read miscompare.
REQ-013 SHALL have port fail_addr, output, ADDR_WIDTH bits: address of the first miscompare.
REQ-014 SHALL have port fail_elem, output, 3 bits: March element index of the first miscompare.
REQ-015 SHALL have port fail_syn, output, DATA_WIDTH bits: rdata XOR expected data at the first miscompare.

Function
REQ-016 SHALL run March C- as six elements:
- M0: any order, w0.
- M1: ascending, r0 then w1.
- M2: ascending, r1 then w0.
- M3: descending, r0 then w1.
- M4: descending, r1 then w0.
- M5: any order, r0.
REQ-017 SHALL use all-zeros as background 0 and all-ones as background 1; M0 and M5 SHALL run in ascending order.
REQ-018 SHALL issue exactly one operation per cycle, with no idle cycles between operations or between elements: 10N operation cycles in total.
REQ-019 SHALL use the states IDLE, RUN and DRAIN:
- IDLE to RUN on start.
- RUN to DRAIN after the last M5 read.
- DRAIN lasts 2 cycles and then returns to IDLE with done=1.
REQ-020 SHALL issue the first operation (M0, address 0) in the cycle after start is sampled.
REQ-021 SHALL drive wdata with the data of a write issued in cycle K during both cycle K-1 and cycle K, because the memory registers wdata internally.
REQ-022 SHALL compare rdata for a read issued in cycle K in cycle K+2 (2-cycle read latency), using a 2-stage pipeline of valid, expected data, address and element index.
REQ-023 SHALL keep DRAIN long enough to evaluate the reads still in the compare pipeline, so the final M5 read is always compared.
REQ-024 SHALL drive write_read=0 and hold address when idle, so no spurious writes occur.
REQ-025 SHALL wrap the address counter with no overflow between the end of one element and the start of the next (ascending N-1 to 0, descending 0 to N-1 for M3 and M4).
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL, on start, clear done, fail and the fail log in the same edge that sets busy.
REQ-028 SHALL continue a test to completion after a failure; fail_* SHALL keep the first miscompare only.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-test, go to IDLE on the next edge.
REQ-030 SHALL reset these outputs to 0: busy, done, fail, write_read, address, wdata, fail_addr, fail_elem, fail_syn.
REQ-031 SHALL clear the compare pipeline on reset, so no stale compare is evaluated after it.

Configuration
REQ-032 SHALL, with MBIST_FAIL_LOG_EN defined, implement fail_addr, fail_elem and fail_syn as in REQ-013 to REQ-015.
REQ-033 SHALL, without MBIST_FAIL_LOG_EN, keep those ports but tie them to 0 and remove their registers; fail behaves the same in both builds.

Structure
REQ-034 SHALL place the following in package mbist_pkg:
- The state enum.
- The element index constants M0 to M5.
- An element descriptor table holding direction, read enable, read value, write enable and write value.
REQ-035 SHALL contain one sub-module, mbist_cmp: the 2-stage compare pipeline and the fail logging.

Verification
REQ-036 SHALL pass with a fault-free memory (N=16): start in cycle 0 gives 160 operation cycles, done=1 in cycle 163, and fail=0.
REQ-037 SHALL detect a stuck-at-1 on bit 2 of address 5: fail=1, fail_addr=5, fail_elem=1, fail_syn=8'h04.
REQ-038 SHALL detect a stuck-at-0 on bit 0 of address 9: fail=1, fail_addr=9, fail_elem=2, fail_syn=8'h01.
REQ-039 SHALL produce the M3 address sequence 15, 14, ..., 0, each address as r0 then w1.
REQ-040 SHALL recover from rst at operation 70: all outputs 0 in the next cycle, and a new start then completes with fail=0.
REQ-041 SHALL ignore start pulses at cycles 10 and 50: the operation sequence is unchanged and done is still in cycle 163.
